// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer controller and the DI select mux.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    LATCH = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } dma_state_e;

  // DI mux select codes; the mux itself lives elsewhere but shares these.
  localparam logic [1:0] SEL_MEM  = 2'b00;
  localparam logic [1:0] SEL_DMA  = 2'b01;
  localparam logic [1:0] SEL_PROT = 2'b10;

  // The engine owns the bus for the whole read/latch/write triplet of a word.
  function automatic logic bus_owned(dma_state_e s);
    return (s == READ) || (s == LATCH) || (s == WRITE);
  endfunction

endpackage

// File: rtl/dma_xfer_ctrl_if.sv
// Bus arbitration and memory access signals between the DMA engine and memory.
interface dma_xfer_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          bus_req;
  logic          bus_gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output bus_req, mem_addr, mem_rd, mem_wr, mem_wdata,
    input  bus_gnt, mem_rdata
  );

  modport slave (
    input  bus_req, mem_addr, mem_rd, mem_wr, mem_wdata,
    output bus_gnt, mem_rdata
  );
endinterface

// File: rtl/dma_ptr_unit.sv
// Source/destination word pointers and the remaining-word down-counter.
module dma_ptr_unit #(
  parameter int AW = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] src_in,
  input  logic [AW-1:0] dst_in,
  input  logic [LW-1:0] len_in,
  output logic [AW-1:0] src_ptr,
  output logic [AW-1:0] dst_ptr,
  output logic          last
);

  logic [LW-1:0] cnt;

  // Load on a new transfer, advance once per written word; pointers wrap mod 2^AW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
    end else if (load) begin
      src_ptr <= src_in;
      dst_ptr <= dst_in;
      cnt     <= len_in;
    end else if (step) begin
      src_ptr <= src_ptr + AW'(1);
      dst_ptr <= dst_ptr + AW'(1);
      if (cnt != '0) cnt <= cnt - LW'(1);
    end
  end

  assign last = (cnt == LW'(1));

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Memory-to-memory DMA engine; owns the DI mux B input while it holds the bus.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// REQ   | bus_req raised, waiting for grant
// READ  | mem_rd at src_ptr
// LATCH | read data returns, captured into data register
// WRITE | mem_wr at dst_ptr, pointers/count advance; grant re-checked here
// DONE  | one-cycle done pulse, bus released
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int LW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW-1:0]        src_addr,
  input  logic [AW-1:0]        dst_addr,
  input  logic [LW-1:0]        len,
  dma_xfer_ctrl_if.master      bus,
  output logic [DW-1:0]        dma_data,
  output logic [1:0]           sel_DI,
  output logic                 busy,
  output logic                 done
);

  dma_state_e    state;
  logic [DW-1:0] data_reg;
  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic          last;
  logic          load;
  logic          step;

  assign load = (state == IDLE) && start && (len != '0);
  assign step = (state == WRITE);

  dma_ptr_unit #(.AW(AW), .LW(LW)) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .src_in  (src_addr),
    .dst_in  (dst_addr),
    .len_in  (len),
    .src_ptr (src_ptr),
    .dst_ptr (dst_ptr),
    .last    (last)
  );

  // Transfer sequencing and data capture; grant loss only acted on after WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_reg <= '0;
    end else begin
      case (state)
        IDLE:    if (start) state <= (len != '0) ? REQ : DONE;
        REQ:     if (bus.bus_gnt) state <= READ;
        READ:    state <= LATCH;
        LATCH: begin
          data_reg <= bus.mem_rdata;
          state    <= WRITE;
        end
        WRITE: begin
          if (last)              state <= DONE;
          else if (!bus.bus_gnt) state <= REQ;
          else                   state <= READ;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bus_req   = (state == REQ) || bus_owned(state);
  assign bus.mem_rd    = (state == READ);
  assign bus.mem_wr    = (state == WRITE);
  assign bus.mem_addr  = (state == READ)  ? src_ptr :
                         (state == WRITE) ? dst_ptr : '0;
  assign bus.mem_wdata = data_reg;

  // During LATCH the register is still loading, so the returning word is
  // forwarded straight to the mux; otherwise the register (held after DONE).
  assign dma_data = (state == LATCH) ? bus.mem_rdata : data_reg;
  assign sel_DI   = bus_owned(state) ? SEL_DMA : SEL_MEM;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Randomized scoreboard bench for dma_xfer_ctrl with a behavioural memory model.
module tb_dma_xfer_ctrl;
  import dma_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam logic [DW-1:0] CPU_IN  = 32'hCAFE_F00D;
  localparam logic [DW-1:0] PROT_IN = 32'h0BAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] dma_data;
  logic [1:0]    sel_DI;
  logic          busy;
  logic          done;
  logic [DW-1:0] di;

  int checks = 0;
  int errors = 0;

  dma_xfer_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  dma_xfer_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .bus      (bus),
    .dma_data (dma_data),
    .sel_DI   (sel_DI),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // DI mux downstream of the engine
  assign di = (sel_DI == SEL_DMA)  ? dma_data :
              (sel_DI == SEL_PROT) ? PROT_IN  : CPU_IN;

  function automatic logic [DW-1:0] init_word(int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // memory: one-cycle read latency
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  logic          mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else begin
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic [AW-1:0] rd_q [$];
  wr_t           wr_q [$];
  int            done_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: copy word by word in order, so overlapping ranges see earlier writes.
  task automatic push_xfer(input logic [AW-1:0] s0, input logic [AW-1:0] d0, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] s;
      logic [AW-1:0] d;
      wr_t w;
      s = s0 + AW'(i);
      d = d0 + AW'(i);
      rd_q.push_back(s);
      w.addr = d;
      w.data = ref_mem[s];
      wr_q.push_back(w);
      ref_mem[d] = ref_mem[s];
    end
    done_q.push_back(n);
  endtask

  // Drive a one-cycle start; returns #1 after the edge that samples it.
  task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n, input bit expect_run);
    @(posedge clk); #1;
    src_addr = s;
    dst_addr = d;
    len      = LW'(n);
    start    = 1'b1;
    if (expect_run) push_xfer(s, d, n);
    @(posedge clk); #1;
    start    = 1'b0;
    src_addr = AW'($urandom);
    dst_addr = AW'($urandom);
    len      = LW'($urandom);
  endtask

  task automatic wait_done(input int budget, input bit rand_gnt);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (rand_gnt) bus.bus_gnt = 1'($urandom_range(0, 1));
    end
    check("done_within_budget", 64'(seen), 64'd1);
  endtask

  // monitor: pops expectations whenever the DUT presents a strobe
  always @(negedge clk) begin
    if (rst_n && mem_ready) begin
      if (bus.mem_rd) begin
        check("rd_expected", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) check("rd_addr", 64'(bus.mem_addr), 64'(rd_q.pop_front()));
      end
      if (bus.mem_wr) begin
        check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", 64'(bus.mem_addr), 64'(w.addr));
          check("wr_data", 64'(bus.mem_wdata), 64'(w.data));
        end
      end
      if (done) begin
        check("done_expected", 64'(done_q.size() != 0), 64'd1);
        if (done_q.size() != 0) void'(done_q.pop_front());
        check("done_after_all_wr", 64'(wr_q.size()), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] r_req, r_rd, r_wr, r_done, r_sel, r_busy;
    logic [DW-1:0] w0, w2, old91, new90;
    int cnt;
    bit flag;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    bus.bus_gnt = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {bus.bus_req, bus.mem_rd, bus.mem_wr, bus.mem_addr, sel_DI, busy, done}, 64'd0);
    check("rst_data", {bus.mem_wdata, dma_data}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_di_cpu", 64'(di), 64'(CPU_IN));

    // 1 + 6: basic copy with timing and DI mux
    bus.bus_gnt = 1'b1;
    w0 = ref_mem[8'h10];
    w2 = ref_mem[8'h12];
    issue(8'h10, 8'h40, 3, 1);
    r_req = '0; r_rd = '0; r_wr = '0; r_done = '0; r_sel = '0; r_busy = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      r_req[k]  = bus.bus_req;
      r_rd[k]   = bus.mem_rd;
      r_wr[k]   = bus.mem_wr;
      r_done[k] = done;
      r_sel[k]  = (sel_DI == SEL_DMA);
      r_busy[k] = busy;
      if (k == 3) check("t6_di_latch", 64'(di), 64'(w0));
      if (k == 4) check("t6_di_write", 64'(di), 64'(w0));
      if (k == 12) begin
        check("t6_di_idle", 64'(di), 64'(CPU_IN));
        check("t1_dma_data_hold", 64'(dma_data), 64'(w2));
      end
    end
    check("t1_req_T1", 64'(r_req[1] & ~r_rd[1]), 64'd1);
    check("t1_rd_T2", 64'(r_rd[2]), 64'd1);
    check("t1_wr_pattern", 64'(r_wr), 64'b0_0100_1001_0000);
    check("t1_done_T11", 64'(r_done), 64'b0_1000_0000_0000);
    check("t1_req_low_done", 64'(r_req[11]), 64'd0);
    check("t1_sel_cycles", 64'($countones(r_sel)), 64'd9);
    check("t1_busy_idle", 64'(r_busy[12]), 64'd0);

    // 2: grant dropped during first WRITE
    issue(8'h20, 8'h60, 2, 1);
    flag = 0;
    for (int n = 0; n < 10 && !flag; n++) begin
      @(negedge clk);
      if (bus.mem_wr) begin flag = 1; bus.bus_gnt = 1'b0; end
    end
    check("t2_first_wr_seen", 64'(flag), 64'd1);
    cnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (bus.bus_req && !bus.mem_rd && !bus.mem_wr && sel_DI == SEL_MEM && busy) cnt++;
    end
    check("t2_parked_in_req", 64'(cnt), 64'd4);
    bus.bus_gnt = 1'b1;
    wait_done(20, 0);
    cnt = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("t2_single_done", 64'(cnt), 64'd0);

    // 3: pointer wrap
    issue(8'hFE, 8'hFF, 3, 1);
    wait_done(20, 0);

    // 4: len=0, then start while busy
    issue(8'h33, 8'h44, 0, 1);
    cnt = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) check("t4_len0_done", 64'({done, busy}), 64'b11);
      if (bus.bus_req) cnt++;
    end
    check("t4_len0_no_req", 64'(cnt), 64'd0);
    issue(8'h30, 8'h70, 2, 1);
    issue(8'hA0, 8'hB0, 5, 0);
    wait_done(30, 0);
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.mem_wr || busy) cnt++;
    end
    check("t4_busy_start_ignored", 64'(cnt), 64'd0);

    // 5: async reset during LATCH of word 2
    old91 = ref_mem[8'h91];
    new90 = ref_mem[8'h80];
    issue(8'h80, 8'h90, 3, 1);
    for (int k = 1; k <= 6; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_outputs", {bus.bus_req, bus.mem_rd, bus.mem_wr, bus.mem_addr, sel_DI, busy, done}, 64'd0);
    check("t5_rst_data", {bus.mem_wdata, dma_data}, 64'd0);
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.mem_wr || done) cnt++;
      if (n == 2) #1 rst_n = 1'b1;
    end
    check("t5_no_wr_no_done", 64'(cnt), 64'd0);
    check("t5_word1_written", 64'(mem[8'h90]), 64'(new90));
    check("t5_word2_not_written", 64'(mem[8'h91]), 64'(old91));
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    // randomized transfers with random grant
    for (int t = 0; t < 10; t++) begin
      logic [AW-1:0] s, d;
      int n;
      s = AW'($urandom);
      d = AW'($urandom);
      n = $urandom_range(0, 6);
      bus.bus_gnt = 1'($urandom_range(0, 1));
      issue(s, d, n, 1);
      wait_done(400, 1);
    end
    bus.bus_gnt = 1'b1;
    repeat (3) @(negedge clk);

    cnt = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) cnt++;
    check("final_mem_image", 64'(cnt), 64'd0);
    check("queues_drained", 64'(rd_q.size() + wr_q.size() + done_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
